// File: rtl/regbank_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, MEM), the register bank write
// port and the hazard-query logic.
//   alu_*/mem_*  : valid/ready writeback requests with destination and data
//   rb_*         : registered register-bank write port
//   q_addr_*     : hazard query addresses, hit_* : pending-write flags
// master = requester/issue side, slave = arbiter.
interface regbank_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              rb_write;
  logic [ADDR_W-1:0] rb_addr_d;
  logic [DATA_W-1:0] rb_data;
  logic [ADDR_W-1:0] q_addr_a;
  logic [ADDR_W-1:0] q_addr_b;
  logic              hit_a;
  logic              hit_b;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output q_addr_a, q_addr_b,
    input  alu_ready, mem_ready, rb_write, rb_addr_d, rb_data, hit_a, hit_b
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  q_addr_a, q_addr_b,
    output alu_ready, mem_ready, rb_write, rb_addr_d, rb_data, hit_a, hit_b
  );
endinterface

// File: rtl/regbank_wb_arbiter.sv
// Round-robin arbiter sharing the register-bank write port between the ALU and
// memory-load writeback paths. Each source has a one-entry holding buffer; one
// buffer drains per cycle into registered rb_write/rb_addr_d/rb_data. hit_a/hit_b
// flag writes still buffered or in flight for the queried read addresses.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : regbank_wb_arbiter_if.slave (requests, write port, hazard query)
module regbank_wb_arbiter #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter bit          ZERO_REG_RO = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  regbank_wb_arbiter_if.slave  bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  logic      alu_full_q, alu_full_d;
  wb_entry_t alu_ent_q,  alu_ent_d;
  logic      mem_full_q, mem_full_d;
  wb_entry_t mem_ent_q,  mem_ent_d;
  logic      rr_q,       rr_d;       // 0: ALU wins a tie, 1: MEM wins a tie
  logic      rb_write_q, rb_write_d;
  wb_entry_t rb_q,       rb_d;

  logic alu_gnt, mem_gnt;
  logic alu_ready, mem_ready;
  logic alu_load, mem_load;

  // Register 0 is hard-wired when ZERO_REG_RO is set.
  function automatic logic is_ro_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG_RO && (a == '0);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_full_q <= 1'b0;
      alu_ent_q  <= '0;
      mem_full_q <= 1'b0;
      mem_ent_q  <= '0;
      rr_q       <= 1'b0;
      rb_write_q <= 1'b0;
      rb_q       <= '0;
    end else begin
      alu_full_q <= alu_full_d;
      alu_ent_q  <= alu_ent_d;
      mem_full_q <= mem_full_d;
      mem_ent_q  <= mem_ent_d;
      rr_q       <= rr_d;
      rb_write_q <= rb_write_d;
      rb_q       <= rb_d;
    end
  end

  // Grant and ready: depend on buffer state only, never on valid.
  always_comb begin
    alu_gnt   = 1'b0;
    mem_gnt   = 1'b0;
    alu_gnt   = alu_full_q && (!mem_full_q || !rr_q);
    mem_gnt   = mem_full_q && (!alu_full_q ||  rr_q);
    alu_ready = !alu_full_q || alu_gnt;
    mem_ready = !mem_full_q || mem_gnt;
  end

  // Next state: buffer drain/reload, pointer rotation, write-port issue.
  always_comb begin
    alu_full_d = alu_full_q;
    alu_ent_d  = alu_ent_q;
    mem_full_d = mem_full_q;
    mem_ent_d  = mem_ent_q;
    rr_d       = rr_q;
    rb_write_d = alu_gnt || mem_gnt;
    rb_d       = rb_q;

    // Writes to a read-only register 0 complete the handshake but are dropped.
    alu_load = bus.alu_valid && alu_ready && !is_ro_zero(bus.alu_addr);
    mem_load = bus.mem_valid && mem_ready && !is_ro_zero(bus.mem_addr);

    if (alu_gnt) begin
      rb_d       = alu_ent_q;
      alu_full_d = 1'b0;
    end else if (mem_gnt) begin
      rb_d       = mem_ent_q;
      mem_full_d = 1'b0;
    end

    // Only a contested grant rotates the pointer.
    if (alu_full_q && mem_full_q) begin
      rr_d = !rr_q;
    end

    // A reload on the draining edge keeps the buffer full.
    if (alu_load) begin
      alu_full_d = 1'b1;
      alu_ent_d  = '{addr: bus.alu_addr, data: bus.alu_data};
    end
    if (mem_load) begin
      mem_full_d = 1'b1;
      mem_ent_d  = '{addr: bus.mem_addr, data: bus.mem_data};
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.mem_ready = mem_ready;
  assign bus.rb_write  = rb_write_q;
  assign bus.rb_addr_d = rb_q.addr;
  assign bus.rb_data   = rb_q.data;

  // Hazard flags: buffered entries plus the write currently on the bank port.
  assign bus.hit_a = !is_ro_zero(bus.q_addr_a) &&
                     ((alu_full_q && (alu_ent_q.addr == bus.q_addr_a)) ||
                      (mem_full_q && (mem_ent_q.addr == bus.q_addr_a)) ||
                      (rb_write_q && (rb_q.addr      == bus.q_addr_a)));
  assign bus.hit_b = !is_ro_zero(bus.q_addr_b) &&
                     ((alu_full_q && (alu_ent_q.addr == bus.q_addr_b)) ||
                      (mem_full_q && (mem_ent_q.addr == bus.q_addr_b)) ||
                      (rb_write_q && (rb_q.addr      == bus.q_addr_b)));

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter with a queue-based reference model.
module tb_regbank_wb_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regbank_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  regbank_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG_RO(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model: pending writes per source, tie preference, bank-port view.
  ent_t              aq[$];
  ent_t              mq[$];
  bit                fav_mem;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_wr_dut = 0;
  int n_wr_exp = 0;
  bit acc_a, acc_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [ADDR_W-1:0] q);
    if (q == '0) return 1'b0;
    return (aq.size() > 0 && aq[0].addr == q) ||
           (mq.size() > 0 && mq[0].addr == q) ||
           (m_write && m_addr == q);
  endfunction

  // One clock cycle: drive, check comb outputs, advance model, check registered outputs.
  task automatic cycle(input bit rst,
                       input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                       input logic [ADDR_W-1:0] qa, input logic [ADDR_W-1:0] qb);
    bit af, mf, ga, gm, ar, mr;
    ent_t nxt;
    reset         = rst;
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_addr  = ma;
    bus.mem_data  = md;
    bus.q_addr_a  = qa;
    bus.q_addr_b  = qb;
    #1;
    af = aq.size() > 0;
    mf = mq.size() > 0;
    ga = af && (!mf || !fav_mem);
    gm = mf && (!af ||  fav_mem);
    ar = !af || ga;
    mr = !mf || gm;
    chk("alu_ready", bus.alu_ready, ar);
    chk("mem_ready", bus.mem_ready, mr);
    chk("hit_a", bus.hit_a, m_hit(qa));
    chk("hit_b", bus.hit_b, m_hit(qb));
    acc_a = av && ar;
    acc_m = mv && mr;
    if (rst) begin
      aq.delete();
      mq.delete();
      fav_mem = 1'b0;
      m_write = 1'b0;
      m_addr  = '0;
      m_data  = '0;
    end else begin
      nxt = '0;
      if (ga)      nxt = aq.pop_front();
      else if (gm) nxt = mq.pop_front();
      if (af && mf) fav_mem = !fav_mem;
      if (acc_a && aa != '0) aq.push_back('{addr: aa, data: ad});
      if (acc_m && ma != '0) mq.push_back('{addr: ma, data: md});
      m_write = ga || gm;
      if (m_write) begin
        m_addr = nxt.addr;
        m_data = nxt.data;
        n_wr_exp++;
      end
    end
    @(posedge clk);
    #1;
    if (bus.rb_write === 1'b1) n_wr_dut++;
    chk("rb_write", bus.rb_write, m_write);
    chk("rb_addr_d", bus.rb_addr_d, m_addr);
    chk("rb_data", bus.rb_data, m_data);
    @(negedge clk);
  endtask

  task automatic idle(input logic [ADDR_W-1:0] qa, input logic [ADDR_W-1:0] qb);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, qa, qb);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
  endtask

  int a_cnt, m_cnt, wr_before;

  initial begin
    reset = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.q_addr_a  = '0;   bus.q_addr_b = '0;
    fav_mem = 1'b0; m_write = 1'b0; m_addr = '0; m_data = '0;
    @(negedge clk);
    do_reset();
    chk("rst_rb_write", bus.rb_write, 1'b0);
    chk("rst_rb_data", bus.rb_data, 32'h0);

    // Single ALU write: visible on the port two edges after acceptance.
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd5, '0);
    chk("t1_not_yet", bus.rb_write, 1'b0);
    idle(5'd5, '0);
    chk("t1_write", bus.rb_write, 1'b1);
    chk("t1_addr", bus.rb_addr_d, 5'd5);
    chk("t1_data", bus.rb_data, 32'hDEADBEEF);
    idle('0, '0);
    chk("t1_one_cycle", bus.rb_write, 1'b0);
    chk("t1_data_hold", bus.rb_data, 32'hDEADBEEF);

    // Simultaneous accept: ALU first, then MEM; next tie favours MEM.
    cycle(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd3, 5'd4);
    idle(5'd3, 5'd4);
    chk("t2_first", bus.rb_addr_d, 5'd3);
    idle('0, '0);
    chk("t2_second", bus.rb_addr_d, 5'd4);
    chk("t2_second_data", bus.rb_data, 32'h22);
    cycle(1'b0, 1'b1, 5'd6, 32'h33, 1'b1, 5'd8, 32'h44, '0, '0);
    idle('0, '0);
    chk("t2_tie_mem", bus.rb_addr_d, 5'd8);
    idle('0, '0);
    chk("t2_tie_alu", bus.rb_addr_d, 5'd6);
    idle('0, '0);

    // Both sources streaming: alternate grants, nothing lost or duplicated.
    do_reset();
    wr_before = n_wr_dut;
    a_cnt = 0; m_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, ADDR_W'(10 + a_cnt), DATA_W'(32'hA000 + a_cnt),
                  1'b1, ADDR_W'(20 + m_cnt), DATA_W'(32'hB000 + m_cnt), 5'd12, 5'd21);
      if (acc_a) a_cnt++;
      if (acc_m) m_cnt++;
    end
    for (int i = 0; i < 4; i++) idle('0, '0);
    chk("t3_alu_accepts", 64'(a_cnt), 64'd5);
    chk("t3_mem_accepts", 64'(m_cnt), 64'd4);
    chk("t3_writes", 64'(n_wr_dut - wr_before), 64'(a_cnt + m_cnt));

    // Write to register 0 is accepted and dropped.
    wr_before = n_wr_dut;
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0, 5'd0, 5'd0);
    chk("t4_accepted", 64'(acc_a), 64'd1);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);
    chk("t4_hit_a", bus.hit_a, 1'b0);
    chk("t4_no_write", 64'(n_wr_dut - wr_before), 64'd0);

    // Pending-write flag follows a MEM entry through to the bank port.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 32'h77, '0, 5'd7);
    chk("t5_hit_buffered", bus.hit_b, 1'b1);
    idle('0, 5'd7);
    chk("t5_hit_inflight", bus.hit_b, 1'b1);
    idle('0, 5'd7);
    chk("t5_hit_clear", bus.hit_b, 1'b0);

    // Reset with both buffers full discards them.
    wr_before = n_wr_dut;
    cycle(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 32'hCC, 5'd9, 5'd12);
    chk("t6_hit_a_full", bus.hit_a, 1'b1);
    do_reset();
    chk("t6_rb_write", bus.rb_write, 1'b0);
    for (int i = 0; i < 3; i++) idle(5'd9, 5'd12);
    chk("t6_alu_ready", bus.alu_ready, 1'b1);
    chk("t6_mem_ready", bus.mem_ready, 1'b1);
    chk("t6_hit_a", bus.hit_a, 1'b0);
    chk("t6_hit_b", bus.hit_b, 1'b0);
    chk("t6_no_write", 64'(n_wr_dut - wr_before), 64'd0);

    chk("total_writes", 64'(n_wr_dut), 64'(n_wr_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
